// File: rtl/display_fetch.sv
// Line-buffered frame fetch: prefetches line Y+1 during line Y into a 2-bank buffer.
// Define DISPLAY_FETCH_STATS_EN to build the saturating underrun counter.
module display_fetch #(
  parameter int CORDW  = 16,
  parameter int ADDRW  = 20,
  parameter int DATAW  = 8,
  parameter int LB_LEN = 2048
) (
  input  logic             clk_pix,
  input  logic             rst_pix_n,
  input  logic [CORDW-1:0] hres,
  input  logic [CORDW-1:0] vres,
  input  logic [ADDRW-1:0] base_addr,
  input  logic [CORDW-1:0] dx,
  input  logic [CORDW-1:0] dy,
  input  logic             de,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             frame_start,
  input  logic             line_start,
  output logic             mem_req,
  output logic [ADDRW-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [DATAW-1:0] mem_data,
  output logic [DATAW-1:0] pix,
  output logic             de_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             underrun,
  output logic [15:0]      underrun_cnt
);

  localparam int IW = $clog2(LB_LEN);
  localparam int NW = IW + 1;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t state;
  logic [ADDRW-1:0] line_addr;
  logic [NW-1:0]    idx;
  logic [NW-1:0]    n_reg;
  logic             bank;

  logic [DATAW-1:0] lb [2][LB_LEN];

  logic signed [CORDW-1:0] hres_s;
  logic signed [CORDW-1:0] dx_s;
  logic signed [CORDW:0]   dy_next;
  logic signed [CORDW:0]   vres_m1;
  logic [NW-1:0]    n_words;
  logic             start;
  logic             ack;
  logic             last;
  logic             abort;
  logic [ADDRW-1:0] la_adv;
  logic [ADDRW-1:0] la_next;
  logic             rd_ok;

  assign hres_s  = $signed(hres);
  assign dx_s    = $signed(dx);
  assign dy_next = $signed({dy[CORDW-1], dy}) + $signed((CORDW+1)'(1));
  assign vres_m1 = $signed({vres[CORDW-1], vres}) - $signed((CORDW+1)'(1));

  always_comb begin
    n_words = '0;
    if (int'(hres_s) > LB_LEN)
      n_words = NW'(LB_LEN);
    else if (int'(hres_s) > 0)
      n_words = NW'(hres_s);
  end

  assign start = line_start && !dy_next[CORDW]
              && (dy_next <= vres_m1) && (n_words != '0);
  assign ack   = mem_req && mem_ack;
  assign last  = ack && (idx == n_reg - 1'b1);
  assign abort = (state == FETCH) && line_start && !last;

  // frame_start wins over the per-line advance of the same cycle
  assign la_adv  = (last || abort) ? line_addr + ADDRW'(hres) : line_addr;
  assign la_next = frame_start ? base_addr : la_adv;

  assign rd_ok = de && !dx_s[CORDW-1] && (int'(dx_s) < LB_LEN);

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      line_addr <= '0;
      idx       <= '0;
      n_reg     <= '0;
      bank      <= 1'b0;
      underrun  <= 1'b0;
      pix       <= '0;
      de_o      <= 1'b0;
      hsync_o   <= 1'b0;
      vsync_o   <= 1'b0;
    end else begin
      line_addr <= la_next;
      de_o      <= de;
      hsync_o   <= hsync;
      vsync_o   <= vsync;
      pix       <= rd_ok ? lb[dy[0]][dx[IW-1:0]] : '0;
      if (abort)
        underrun <= 1'b1;
      if (start) begin
        state    <= FETCH;
        mem_req  <= 1'b1;
        mem_addr <= la_next;
        idx      <= '0;
        n_reg    <= n_words;
        bank     <= dy_next[0];
      end else if (last || abort) begin
        state   <= IDLE;
        mem_req <= 1'b0;
      end else if (ack) begin
        idx      <= idx + 1'b1;
        mem_addr <= mem_addr + 1'b1;
      end
    end
  end

  // Buffer contents survive reset
  always_ff @(posedge clk_pix) begin
    if (ack)
      lb[bank][idx[IW-1:0]] <= mem_data;
  end

`ifdef DISPLAY_FETCH_STATS_EN
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n)
      underrun_cnt <= '0;
    else if (abort && underrun_cnt != 16'hFFFF)
      underrun_cnt <= underrun_cnt + 16'd1;
  end
`else
  assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_display_fetch.sv
// Self-checking bench for display_fetch: address scoreboard plus pixel vector table.
// Honours DISPLAY_FETCH_STATS_EN for the expected underrun count.
module tb_display_fetch;

  localparam int LBL = 2048;

  logic        clk = 1'b0;
  logic        rst_pix_n = 1'b0;
  logic [15:0] hres = '0;
  logic [15:0] vres = '0;
  logic [19:0] base_addr = '0;
  logic [15:0] dx = '0;
  logic [15:0] dy = '0;
  logic        de = 1'b0;
  logic        hsync = 1'b0;
  logic        vsync = 1'b0;
  logic        frame_start = 1'b0;
  logic        line_start = 1'b0;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic [7:0]  pix;
  logic        de_o;
  logic        hsync_o;
  logic        vsync_o;
  logic        underrun;
  logic [15:0] underrun_cnt;

  int tests = 0;
  int fails = 0;
  logic slow = 1'b0;
  logic [1:0] acnt = '0;
  int exp_q[$];

  display_fetch dut (
    .clk_pix      (clk),
    .rst_pix_n    (rst_pix_n),
    .hres         (hres),
    .vres         (vres),
    .base_addr    (base_addr),
    .dx           (dx),
    .dy           (dy),
    .de           (de),
    .hsync        (hsync),
    .vsync        (vsync),
    .frame_start  (frame_start),
    .line_start   (line_start),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_data     (mem_data),
    .pix          (pix),
    .de_o         (de_o),
    .hsync_o      (hsync_o),
    .vsync_o      (vsync_o),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  // Memory model: ack every cycle, or every 4th requested cycle
  assign mem_ack  = mem_req && (slow ? (acnt == 2'd3) : 1'b1);
  assign mem_data = mem_addr[7:0];

  always @(posedge clk) begin
    if (!mem_req) acnt <= '0;
    else          acnt <= acnt + 2'd1;
  end

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_pix_n && mem_req && mem_ack) begin
      if (exp_q.size() == 0)
        chk("unexpected_ack", int'(mem_addr), -1);
      else
        chk("ack_addr", int'(mem_addr), exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_line(int a, int n);
    for (int i = 0; i < n; i++) exp_q.push_back(a + i);
  endtask

  task automatic fetch_line(int y);
    dy = 16'(y);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic new_frame(int b);
    base_addr = 20'(b);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_done(int max);
    for (int k = 0; k < max; k++) begin
      if (!mem_req && exp_q.size() == 0) break;
      tick();
    end
    chk("req_low", int'(mem_req), 0);
    chk("queue_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic chk_pix(string name, int x, int y, int e);
    dx = 16'(x);
    dy = 16'(y);
    de = 1'b1;
    tick();
    chk(name, int'(pix), e);
    de = 1'b0;
  endtask

  typedef struct {
    int dx;
    int dy;
    bit de;
    bit hs;
    bit vs;
    int pix;
  } vec_t;

  vec_t vt[12];

  initial begin
    vt[0]  = '{0, 0, 1, 0, 0, 8'h00};
    vt[1]  = '{1, 0, 1, 0, 0, 8'h01};
    vt[2]  = '{2, 0, 1, 0, 0, 8'h02};
    vt[3]  = '{3, 0, 1, 0, 0, 8'h03};
    vt[4]  = '{4, 0, 1, 0, 0, 8'h04};
    vt[5]  = '{5, 0, 1, 1, 1, 8'h05};
    vt[6]  = '{6, 0, 1, 0, 0, 8'h06};
    vt[7]  = '{7, 0, 1, 0, 0, 8'h07};
    vt[8]  = '{3, 0, 0, 1, 0, 8'h00};
    vt[9]  = '{2, 1, 1, 0, 0, 8'h0A};
    vt[10] = '{7, 1, 1, 0, 1, 8'h0F};
    vt[11] = '{-1, 0, 1, 0, 0, 8'h00};

    // Reset state
    repeat (2) tick();
    chk("rst_req", int'(mem_req), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_pix", int'(pix), 0);
    chk("rst_de", int'(de_o), 0);
    chk("rst_hs", int'(hsync_o), 0);
    chk("rst_vs", int'(vsync_o), 0);
    chk("rst_ur", int'(underrun), 0);
    chk("rst_urc", int'(underrun_cnt), 0);
    rst_pix_n = 1'b1;
    hres = 16'd8;
    vres = 16'd4;
    tick();

    // Two back-to-back line prefetches
    new_frame(20'h100);
    push_line(20'h100, 8);
    fetch_line(-1);
    wait_done(20);
    push_line(20'h108, 8);
    fetch_line(0);
    wait_done(20);

    // Pixel readout, one-cycle latency, streamed
    for (int i = 0; i < 12; i++) begin
      dx = 16'(vt[i].dx);
      dy = 16'(vt[i].dy);
      de = vt[i].de;
      hsync = vt[i].hs;
      vsync = vt[i].vs;
      tick();
      chk($sformatf("pix%0d", i), int'(pix), vt[i].pix);
      chk($sformatf("de%0d", i), int'(de_o), int'(vt[i].de));
      chk($sformatf("hs%0d", i), int'(hsync_o), int'(vt[i].hs));
      chk($sformatf("vs%0d", i), int'(vsync_o), int'(vt[i].vs));
    end
    de = 1'b0;
    hsync = 1'b0;
    vsync = 1'b0;
    chk("no_ur_yet", int'(underrun), 0);

    // Underrun: ack every 4th cycle, line period 20
    slow = 1'b1;
    new_frame(20'h200);
    push_line(20'h200, 5);
    fetch_line(-1);
    repeat (19) tick();
    push_line(20'h208, 8);
    fetch_line(0);
    chk("ur_flag", int'(underrun), 1);
`ifdef DISPLAY_FETCH_STATS_EN
    chk("ur_cnt", int'(underrun_cnt), 1);
`else
    chk("ur_cnt", int'(underrun_cnt), 0);
`endif
    wait_done(60);
    slow = 1'b0;

    // Last line: no fetch; then new frame base
    fetch_line(3);
    for (int i = 0; i < 3; i++) begin
      chk("last_line_req", int'(mem_req), 0);
      tick();
    end
    new_frame(20'h400);
    push_line(20'h400, 8);
    fetch_line(-1);
    wait_done(20);

    // Asynchronous reset in the middle of a fetch
    new_frame(20'h500);
    push_line(20'h500, 3);
    fetch_line(-1);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_addr", int'(mem_addr), 20'h503);
    #2;
    rst_pix_n = 1'b0;
    #1;
    chk("arst_req", int'(mem_req), 0);
    chk("arst_addr", int'(mem_addr), 0);
    chk("arst_ur", int'(underrun), 0);
    chk("arst_urc", int'(underrun_cnt), 0);
    chk("arst_pix", int'(pix), 0);
    chk("arst_de", int'(de_o), 0);
    chk("arst_q", exp_q.size(), 0);
    repeat (2) tick();
    rst_pix_n = 1'b1;
    tick();
    push_line(0, 8);
    fetch_line(-1);
    wait_done(20);

    // Line longer than the buffer
    hres = 16'(LBL + 4);
    new_frame(20'h1000);
    push_line(20'h1000, LBL);
    fetch_line(-1);
    wait_done(LBL + 50);
    chk_pix("lb_last", LBL - 1, 0, 8'hFF);
    chk_pix("lb_over0", LBL, 0, 0);
    chk_pix("lb_over3", LBL + 3, 0, 0);
    chk_pix("lb_first", 0, 0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
